// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b decode types for the ID stage.
//   lc3b_opcode      - IR[15:12] opcode enum
//   lc3b_reg/word    - 3-bit register index, 16-bit data word
//   lc3b_operand_use - which registers an instruction reads/writes
//   decode_operands  - combinational operand decode of an IR word
// Unused operand indices still carry the IR field so the regfile
// read ports always show a defined register.
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDW = 4'h6, OP_STW = 4'h7,
    OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
    OP_JMP  = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_reg sr1_idx;
    logic    sr1_use;
    lc3b_reg sr2_idx;
    logic    sr2_use;
    lc3b_reg dest_idx;
    logic    writes;
  } lc3b_operand_use;

  function automatic lc3b_operand_use decode_operands(input lc3b_word ir);
    lc3b_operand_use u;
    u.sr1_idx  = ir[8:6];
    u.sr1_use  = 1'b0;
    u.sr2_idx  = ir[2:0];
    u.sr2_use  = 1'b0;
    u.dest_idx = ir[11:9];
    u.writes   = 1'b0;
    case (lc3b_opcode'(ir[15:12]))
      OP_ADD, OP_AND: begin
        u.sr1_use = 1'b1;
        u.sr2_use = ~ir[5];   // IR[5]=1 selects the immediate form
        u.writes  = 1'b1;
      end
      OP_NOT, OP_SHF, OP_LDB, OP_LDW, OP_LDI: begin
        u.sr1_use = 1'b1;
        u.writes  = 1'b1;
      end
      OP_LEA: u.writes = 1'b1;
      OP_STB, OP_STW, OP_STI: begin
        // store data source lives in the dest field
        u.sr1_use = 1'b1;
        u.sr2_idx = ir[11:9];
        u.sr2_use = 1'b1;
      end
      OP_JMP: u.sr1_use = 1'b1;
      OP_JSR: begin
        u.dest_idx = 3'd7;
        u.writes   = 1'b1;
        u.sr1_use  = ~ir[11];  // JSRR reads its base register
      end
      OP_TRAP: begin
        u.dest_idx = 3'd7;
        u.writes   = 1'b1;
      end
      default: ;               // BR, RTI: no register operands
    endcase
    return u;
  endfunction

endpackage

// File: rtl/scoreboard_counters.sv
// scoreboard_counters: per-register count of in-flight writers.
//   clk, reset : clock, synchronous active-high reset
//   inc[8]     : a writer to register r issues this cycle
//   dec[8]     : a writer to register r retires this cycle
//   cnt[8]     : current pending count per register
//   error      : sticky, a retire arrived for a register with count 0
// Counts saturate at both ends; inc and dec together cancel.
module scoreboard_counters #(
  parameter int CNT_W = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   inc,
  input  logic [7:0]                   dec,
  output logic [7:0][CNT_W-1:0]        cnt,
  output logic                         error
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0] zero;

  always_comb begin
    zero = '0;
    for (int r = 0; r < 8; r++) zero[r] = (cnt[r] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (inc[r] && !dec[r] && cnt[r] != CNT_MAX)
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r] && !zero[r])
          cnt[r] <= cnt[r] - 1'b1;
      end
      if (|(dec & zero)) error <= 1'b1;
    end
  end

endmodule

// File: rtl/id_scoreboard_regfile.sv
// id_scoreboard_regfile: LC-3b decode-stage operand fetch + hazard stall.
//   clk, reset        : clock, synchronous active-high reset
//   ir_in, valid_in   : instruction in ID from the IF/ID barrier
//   stall_in, flush   : downstream hold / squash of the ID instruction
//   retire_*          : writer leaving WB (load=0 means squashed writer)
//   sr1_out, sr2_out  : operands to ID/EX, valid in the issue cycle
//   issue             : ID instruction accepted (ID/EX valid)
//   stall_out         : hold IF/ID and pc
//   error_out         : sticky, retire seen on a register with no writers
// Optional: ID_WRITE_BYPASS_EN forwards a same-cycle retire into the
// operand reads and the hazard check, removing one stall cycle.
module id_scoreboard_regfile
  import lc3b_types::*;
#(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        retire_valid,
  input  logic [2:0]  retire_dest,
  input  logic        retire_load,
  input  logic [15:0] retire_data,
  output logic [15:0] sr1_out,
  output logic [15:0] sr2_out,
  output logic        issue,
  output logic        stall_out,
  output logic        error_out
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lc3b_operand_use        ou;
  logic [7:0][15:0]       rf;
  logic [7:0][CNT_W-1:0]  cnt, cnt_eff;
  logic [7:0]             inc_vec, dec_vec;
  logic                   wr_en, hazard;

  assign ou      = decode_operands(ir_in);
  assign wr_en   = retire_valid & retire_load;
  assign dec_vec = retire_valid ? (8'b1 << retire_dest) : 8'b0;
  assign inc_vec = (issue & ou.writes) ? (8'b1 << ou.dest_idx) : 8'b0;

`ifdef ID_WRITE_BYPASS_EN
  // A retiring writer is already counted as gone; its data is forwarded.
  always_comb begin
    cnt_eff = cnt;
    for (int r = 0; r < 8; r++)
      cnt_eff[r] = cnt[r] - CNT_W'(dec_vec[r] && cnt[r] != '0);
  end
  assign sr1_out = (wr_en && retire_dest == ou.sr1_idx) ? retire_data : rf[ou.sr1_idx];
  assign sr2_out = (wr_en && retire_dest == ou.sr2_idx) ? retire_data : rf[ou.sr2_idx];
`else
  assign cnt_eff = cnt;
  assign sr1_out = rf[ou.sr1_idx];
  assign sr2_out = rf[ou.sr2_idx];
`endif

  // Sources wait for all pending writers; a destination only waits when
  // its counter has no room for another in-flight writer.
  always_comb begin
    hazard = valid_in & (
               (ou.sr1_use & (cnt_eff[ou.sr1_idx] != '0)) |
               (ou.sr2_use & (cnt_eff[ou.sr2_idx] != '0)) |
               (ou.writes  & (cnt_eff[ou.dest_idx] == CNT_MAX)));
  end

  assign issue     = valid_in & ~hazard & ~stall_in & ~flush & ~reset;
  assign stall_out = (hazard | stall_in) & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset)      rf <= '0;
    else if (wr_en) rf[retire_dest] <= retire_data;
  end

  scoreboard_counters #(.CNT_W(CNT_W)) u_sb (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_vec),
    .dec   (dec_vec),
    .cnt   (cnt),
    .error (error_out)
  );

endmodule

// File: tb/tb_id_scoreboard_regfile.sv
module tb_id_scoreboard_regfile;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef ID_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, valid_in, stall_in, flush;
  logic        retire_valid, retire_load;
  logic [2:0]  retire_dest;
  logic [15:0] ir_in, retire_data, sr1_out, sr2_out;
  logic        issue, stall_out, error_out;

  always #5 clk = ~clk;

  id_scoreboard_regfile #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .valid_in(valid_in),
    .stall_in(stall_in), .flush(flush), .retire_valid(retire_valid),
    .retire_dest(retire_dest), .retire_load(retire_load),
    .retire_data(retire_data), .sr1_out(sr1_out), .sr2_out(sr2_out),
    .issue(issue), .stall_out(stall_out), .error_out(error_out)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: register values, writer counts, in-flight writer list
  logic [15:0] m_rf [8];
  int          m_cnt [8];
  bit          m_err;
  int          inflight [$];

  function automatic void ops(input logic [15:0] ir,
                              output int s1, output bit u1,
                              output int s2, output bit u2,
                              output int d,  output bit w);
    int op;
    op = int'(ir[15:12]);
    s1 = int'(ir[8:6]); s2 = int'(ir[2:0]); d = int'(ir[11:9]);
    u1 = 0; u2 = 0; w = 0;
    if (op == 1 || op == 5) begin u1 = 1; u2 = !ir[5]; w = 1; end
    else if (op == 9 || op == 13 || op == 2 || op == 6 || op == 10) begin u1 = 1; w = 1; end
    else if (op == 14) w = 1;
    else if (op == 3 || op == 7 || op == 11) begin u1 = 1; u2 = 1; s2 = int'(ir[11:9]); end
    else if (op == 12) u1 = 1;
    else if (op == 4) begin d = 7; w = 1; u1 = !ir[11]; end
    else if (op == 15) begin d = 7; w = 1; end
  endfunction

  function automatic int eff(input int r);
    int e;
    e = m_cnt[r];
    if (BYP && retire_valid && int'(retire_dest) == r && e > 0) e--;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic [15:0] ir, input bit v, input bit si, input bit fl,
                     input bit rv, input int rd, input bit rl, input logic [15:0] rdata,
                     input bit rst);
    ir_in = ir; valid_in = v; stall_in = si; flush = fl;
    retire_valid = rv; retire_dest = 3'(rd); retire_load = rl;
    retire_data = rdata; reset = rst;
  endtask

  // check all outputs against the model, clock once, advance the model
  task automatic cyc(input string tag);
    int s1, s2, d; bit u1, u2, w, haz, ei, es;
    logic [15:0] e1, e2;
    #1;
    ops(ir_in, s1, u1, s2, u2, d, w);
    haz = valid_in && ((u1 && eff(s1) != 0) || (u2 && eff(s2) != 0) || (w && eff(d) == MAXC));
    ei  = valid_in && !haz && !stall_in && !flush && !reset;
    es  = (haz || stall_in) && !flush && !reset;
    e1  = (BYP && retire_valid && retire_load && int'(retire_dest) == s1) ? retire_data : m_rf[s1];
    e2  = (BYP && retire_valid && retire_load && int'(retire_dest) == s2) ? retire_data : m_rf[s2];
    chk({tag, ".issue"}, 16'(issue), 16'(ei));
    chk({tag, ".stall"}, 16'(stall_out), 16'(es));
    chk({tag, ".sr1"}, sr1_out, e1);
    chk({tag, ".sr2"}, sr2_out, e2);
    chk({tag, ".err"}, 16'(error_out), 16'(m_err));
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 8; r++) begin m_rf[r] = '0; m_cnt[r] = 0; end
      m_err = 0;
      inflight.delete();
    end else begin
      if (retire_valid && retire_load) m_rf[retire_dest] = retire_data;
      if (retire_valid && m_cnt[retire_dest] == 0) m_err = 1;
      if (ei && w) begin m_cnt[d]++; inflight.push_back(d); end
      if (retire_valid) begin
        if (m_cnt[retire_dest] > 0) m_cnt[retire_dest]--;
        for (int i = 0; i < inflight.size(); i++)
          if (inflight[i] == int'(retire_dest)) begin inflight.delete(i); break; end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 32 && inflight.size() > 0; k++) begin
      set(16'h0000, 0, 0, 0, 1, inflight[0], 1, 16'($urandom), 0);
      cyc("drain");
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin m_rf[r] = '0; m_cnt[r] = 0; end
    m_err = 0;
    set(16'h1283, 1, 0, 0, 0, 0, 0, 16'h0, 1);
    @(negedge clk);
    cyc("reset0");
    cyc("reset1");

    // ADD R1,R2,R3 issues with zero operands
    set(16'h1283, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    #1; chk("add_first.issue", 16'(issue), 16'h1);
    cyc("add_first");
    set(16'h0000, 0, 0, 0, 1, 1, 1, 16'h0000, 0);
    cyc("ret_r1_0");

    // RAW on R1
    set(16'h1261, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("add_r1_inc");
    set(16'h1860, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    #1; chk("raw_stall.stall", 16'(stall_out), 16'h1);
    chk("raw_stall.issue", 16'(issue), 16'h0);
    cyc("raw_stall0");
    cyc("raw_stall1");
    set(16'h1860, 1, 0, 0, 1, 1, 1, 16'h0005, 0);
`ifdef ID_WRITE_BYPASS_EN
    #1; chk("raw_bypass.issue", 16'(issue), 16'h1);
    chk("raw_bypass.sr1", sr1_out, 16'h0005);
`else
    #1; chk("raw_nobyp.issue", 16'(issue), 16'h0);
`endif
    cyc("raw_retire");
    set(16'h1860, 0, 0, 0, 0, 0, 0, 16'h0, 0);
`ifndef ID_WRITE_BYPASS_EN
    valid_in = 1'b1;
    #1; chk("raw_late.issue", 16'(issue), 16'h1);
    chk("raw_late.sr1", sr1_out, 16'h0005);
`endif
    cyc("raw_after");
    drain();

    // counter capacity on R2
    set(16'h6580, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("ldw1"); cyc("ldw2"); cyc("ldw3");
    #1; chk("ldw4.stall", 16'(stall_out), 16'h1);
    cyc("ldw4_full");
    set(16'h6580, 1, 0, 0, 1, 2, 1, 16'h1234, 0);
    cyc("ldw4_retire");
    set(16'h6580, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("ldw4_late");
    set(16'h0000, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("idle");
    drain();
    set(16'h0000, 0, 0, 0, 1, 2, 1, 16'h7777, 0);
    cyc("ret_zero");
    set(16'h0000, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    #1; chk("ret_zero.error_out", 16'(error_out), 16'h1);
    cyc("err_sticky");

    // store data dependency
    set(16'h1620, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("add_r3");
    set(16'h7780, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("stw_stall");
    set(16'h7780, 1, 0, 0, 1, 3, 1, 16'hBEEF, 0);
    cyc("stw_retire");
    set(16'h7780, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    #1; chk("stw.sr2", sr2_out, 16'hBEEF);
    cyc("stw_after");
    drain();

    // issue and retire on R5 in the same cycle
    set(16'h1A20, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("r5_w1");
    set(16'h1A20, 1, 0, 0, 1, 5, 1, 16'h0055, 0);
    cyc("r5_both");
    set(16'h1160, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    #1; chk("r5_pending.stall", 16'(stall_out), 16'h1);
    cyc("r5_pending");
    drain();

    // flush during a hazard stall
    set(16'h1261, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("fl_w");
    set(16'h1860, 1, 0, 1, 0, 0, 0, 16'h0, 0);
    #1; chk("flush.stall", 16'(stall_out), 16'h0);
    cyc("flush");
    set(16'h1860, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    cyc("flush_after");

    // reset during a stall
    set(16'h1860, 1, 0, 0, 0, 0, 0, 16'h0, 1);
    cyc("mid_reset");
    set(16'h1860, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    #1; chk("post_reset.issue", 16'(issue), 16'h1);
    chk("post_reset.sr1", sr1_out, 16'h0000);
    cyc("post_reset");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit rv; int rd;
      rv = inflight.size() > 0 && $urandom_range(0, 1) == 1;
      rd = rv ? inflight[$urandom_range(0, inflight.size() - 1)] : int'($urandom_range(0, 7));
      set(16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, rv, rd, $urandom_range(0, 5) != 0,
          16'($urandom), 0);
      cyc("rand");
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
